// File: rtl/board_pkg.sv
// Shared constants for the board wrapper: seven-segment table, pushbutton roles,
// input reset values and the parked SRAM pin levels.
package board_pkg;

  // Active-low segments {g,f,e,d,c,b,a}, indexed by nibble value.
  localparam logic [15:0][6:0] HEX_SEG = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  localparam int KEY_LIVE  = 0;
  localparam int KEY_SHIFT = 1;
  localparam int KEY_ADD   = 2;
  localparam int KEY_CLR   = 3;

  localparam logic [16:0] SW_RST  = 17'h0;
  localparam logic [3:0]  KEY_RST = 4'hF;

  localparam logic [17:0] SRAM_IDLE_ADDR   = 18'h0;
  localparam logic        SRAM_IDLE_CTRL_N = 1'b1;

  typedef enum logic [1:0] {
    CMD_NONE,
    CMD_SHIFT,
    CMD_ADD,
    CMD_CLR
  } cmd_t;

  // Clear beats add, add beats shift when presses land in the same cycle.
  function automatic cmd_t pick_cmd(input logic [3:0] press);
    cmd_t cmd;
    cmd = CMD_NONE;
    if (press[KEY_CLR])        cmd = CMD_CLR;
    else if (press[KEY_ADD])   cmd = CMD_ADD;
    else if (press[KEY_SHIFT]) cmd = CMD_SHIFT;
    return cmd;
  endfunction

endpackage

// File: rtl/board_wrapper_hex7seg.sv
// Nibble to active-low seven-segment decoder, one per display digit.
module hex7seg_decoder
  import board_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = HEX_SEG[nibble];

endmodule

// File: rtl/board_wrapper.sv
// Board top: synchronised switches/keys mirrored on LEDs, a key-driven 32-bit
// display register shown on eight hex digits, and the SRAM parked idle.
module board_wrapper
  import board_pkg::*;
#(
  parameter int HB_WIDTH = 24
) (
  input  logic        CLOCK_50,
  input  logic [17:0] SW,
  input  logic [3:0]  KEY,
  output logic [17:0] LEDR,
  output logic [8:0]  LEDG,
  output logic [6:0]  HEX0,
  output logic [6:0]  HEX1,
  output logic [6:0]  HEX2,
  output logic [6:0]  HEX3,
  output logic [6:0]  HEX4,
  output logic [6:0]  HEX5,
  output logic [6:0]  HEX6,
  output logic [6:0]  HEX7,
  output logic [17:0] SRAM_ADDR,
  inout  wire  [15:0] SRAM_DQ,
  output logic        SRAM_CE_N,
  output logic        SRAM_WE_N,
  output logic        SRAM_LB_N,
  output logic        SRAM_UB_N,
  output logic        SRAM_OE_N
);

  localparam logic [HB_WIDTH-1:0] HB_ONE = {{(HB_WIDTH-1){1'b0}}, 1'b1};

  logic              rst_n;
  logic [1:0]        rst_sync;
  logic              rst_int_n;

  logic [16:0]       sw_meta;
  logic [16:0]       sw_sync;
  logic [3:0]        key_meta;
  logic [3:0]        key_sync;
  logic [3:0]        key_prev;
  logic [3:0]        press;

  logic [31:0]       disp;
  logic [31:0]       disp_next;
  logic [31:0]       shown;
  logic [HB_WIDTH-1:0] hb;
  logic [6:0]        seg [8];

  assign rst_n = SW[17];

  // Assertion is immediate; release waits two clean edges.
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) rst_sync <= 2'b00;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_int_n = rst_sync[1];

  always_ff @(posedge CLOCK_50 or negedge rst_int_n) begin
    if (!rst_int_n) begin
      sw_meta  <= SW_RST;
      sw_sync  <= SW_RST;
      key_meta <= KEY_RST;
      key_sync <= KEY_RST;
      key_prev <= KEY_RST;
    end else begin
      sw_meta  <= SW[16:0];
      sw_sync  <= sw_meta;
      key_meta <= KEY;
      key_sync <= key_meta;
      key_prev <= key_sync;
    end
  end

  // A press is the released-to-held transition, so a held key fires only once.
  assign press = key_prev & ~key_sync;

  always_comb begin
    disp_next = disp;
    case (pick_cmd(press))
      CMD_CLR:   disp_next = 32'h0;
      CMD_ADD:   disp_next = disp + {15'b0, sw_sync};
      CMD_SHIFT: disp_next = {disp[15:0], sw_sync[15:0]};
      default:   disp_next = disp;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge rst_int_n) begin
    if (!rst_int_n) begin
      disp <= 32'h0;
      hb   <= '0;
    end else begin
      disp <= disp_next;
      hb   <= hb + HB_ONE;
    end
  end

  assign shown = key_sync[KEY_LIVE] ? disp : {15'b0, sw_sync};

  for (genvar d = 0; d < 8; d++) begin : g_hex
    hex7seg_decoder u_dec (
      .nibble (shown[4*d +: 4]),
      .seg    (seg[d])
    );
  end

  assign HEX0 = seg[0];
  assign HEX1 = seg[1];
  assign HEX2 = seg[2];
  assign HEX3 = seg[3];
  assign HEX4 = seg[4];
  assign HEX5 = seg[5];
  assign HEX6 = seg[6];
  assign HEX7 = seg[7];

  assign LEDR = {rst_int_n, sw_sync};
  assign LEDG = {hb[HB_WIDTH-1], 4'b0000, ~key_sync};

  assign SRAM_ADDR = SRAM_IDLE_ADDR;
  assign SRAM_CE_N = SRAM_IDLE_CTRL_N;
  assign SRAM_WE_N = SRAM_IDLE_CTRL_N;
  assign SRAM_OE_N = SRAM_IDLE_CTRL_N;
  assign SRAM_LB_N = SRAM_IDLE_CTRL_N;
  assign SRAM_UB_N = SRAM_IDLE_CTRL_N;
  assign SRAM_DQ   = 16'bz;

endmodule

// File: tb/tb_board_wrapper.sv
// Self-checking bench for board_wrapper: history-based reference model compared
// every cycle, plus hand-computed literal checks on the directed scenarios.
module tb_board_wrapper;

  localparam int TB_HB = 4;
  localparam int D     = 8192;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [16:0] sw_data = 17'h0;
  logic [3:0]  key = 4'hF;
  logic [17:0] sw_bus;
  logic [17:0] ledr;
  logic [8:0]  ledg;
  logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5, hex6, hex7;
  logic [17:0] sram_addr;
  wire  [15:0] sram_dq;
  logic        sram_ce_n, sram_we_n, sram_lb_n, sram_ub_n, sram_oe_n;
  logic [6:0]  hx [8];

  int n_cmp = 0;
  int n_bad = 0;

  assign sw_bus = {rst_n, sw_data};
  assign hx[0] = hex0; assign hx[1] = hex1; assign hx[2] = hex2; assign hx[3] = hex3;
  assign hx[4] = hex4; assign hx[5] = hex5; assign hx[6] = hex6; assign hx[7] = hex7;

  always #5 clk = ~clk;

  board_wrapper #(.HB_WIDTH(TB_HB)) dut (
    .CLOCK_50  (clk),
    .SW        (sw_bus),
    .KEY       (key),
    .LEDR      (ledr),
    .LEDG      (ledg),
    .HEX0      (hex0),
    .HEX1      (hex1),
    .HEX2      (hex2),
    .HEX3      (hex3),
    .HEX4      (hex4),
    .HEX5      (hex5),
    .HEX6      (hex6),
    .HEX7      (hex7),
    .SRAM_ADDR (sram_addr),
    .SRAM_DQ   (sram_dq),
    .SRAM_CE_N (sram_ce_n),
    .SRAM_WE_N (sram_we_n),
    .SRAM_LB_N (sram_lb_n),
    .SRAM_UB_N (sram_ub_n),
    .SRAM_OE_N (sram_oe_n)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  function automatic logic [6:0] seg_of(input logic [3:0] n);
    case (n)
      4'h0: return 7'h40; 4'h1: return 7'h79; 4'h2: return 7'h24; 4'h3: return 7'h30;
      4'h4: return 7'h19; 4'h5: return 7'h12; 4'h6: return 7'h02; 4'h7: return 7'h78;
      4'h8: return 7'h00; 4'h9: return 7'h10; 4'hA: return 7'h08; 4'hB: return 7'h03;
      4'hC: return 7'h46; 4'hD: return 7'h21; 4'hE: return 7'h06; default: return 7'h0E;
    endcase
  endfunction

  // ---------------- reference model ----------------
  // Every recorded edge keeps the raw inputs and whether logic was out of reset
  // before that edge; a synchronised value is the raw value one recorded edge
  // earlier, provided both edges were live.
  bit          live_a [D];
  logic [16:0] sw_a   [D];
  logic [3:0]  key_a  [D];
  int          e = 0;
  int          rise = 0;
  logic [31:0] m_disp = 32'h0;
  int          m_hb = 0;

  function automatic logic [16:0] sync_sw(input int k);
    if (k < 1) return 17'h0;
    if (live_a[k % D] && live_a[(k-1) % D]) return sw_a[(k-1) % D];
    return 17'h0;
  endfunction

  function automatic logic [3:0] sync_key(input int k);
    if (k < 1) return 4'hF;
    if (live_a[k % D] && live_a[(k-1) % D]) return key_a[(k-1) % D];
    return 4'hF;
  endfunction

  function automatic logic [31:0] apply_cmd(input logic [31:0] cur, input int n);
    logic [3:0]  pr;
    logic [16:0] s;
    pr = sync_key(n-2) & ~sync_key(n-1);
    s  = sync_sw(n-1);
    if (pr[3])      return 32'h0;
    else if (pr[2]) return cur + {15'b0, s};
    else if (pr[1]) return {cur[15:0], s[15:0]};
    return cur;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rise           <= 0;
      m_disp         <= 32'h0;
      m_hb           <= 0;
      live_a[e % D]  <= 1'b0;
      e              <= e + 1;
    end else begin
      live_a[e % D]  <= (rise >= 2);
      sw_a[e % D]    <= sw_data;
      key_a[e % D]   <= key;
      e              <= e + 1;
      if (rise < 2) rise <= rise + 1;
      if (rise >= 2) begin
        m_hb   <= m_hb + 1;
        m_disp <= apply_cmd(m_disp, e);
      end else begin
        m_hb   <= 0;
        m_disp <= 32'h0;
      end
    end
  end

  always @(negedge clk) begin
    logic [17:0] x_ledr;
    logic [8:0]  x_ledg;
    logic [55:0] x_hex;
    logic [31:0] v;
    logic [16:0] ssw;
    logic [3:0]  skey;
    if (rst_n && rise >= 2) begin
      ssw    = sync_sw(e - 1);
      skey   = sync_key(e - 1);
      v      = skey[0] ? m_disp : {15'b0, ssw};
      x_ledr = {1'b1, ssw};
      x_ledg = {1'(((m_hb >> (TB_HB-1)) % 2)), 4'b0000, ~skey};
    end else begin
      v      = 32'h0;
      x_ledr = 18'h0;
      x_ledg = 9'h0;
    end
    for (int d = 0; d < 8; d++) x_hex[7*d +: 7] = seg_of(v[4*d +: 4]);
    chk("ledr", 64'(ledr), 64'(x_ledr));
    chk("ledg", 64'(ledg), 64'(x_ledg));
    chk("hex", 64'({hex7, hex6, hex5, hex4, hex3, hex2, hex1, hex0}), 64'(x_hex));
    chk("sram", 64'({sram_addr, sram_ce_n, sram_we_n, sram_oe_n, sram_lb_n, sram_ub_n}),
        64'({18'h0, 5'b11111}));
  end

  // ---------------- directed stimulus ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic press(input logic [3:0] pattern, input int hold);
    key = pattern;
    step(hold);
    key = 4'hF;
    step(4);
  endtask

  task automatic chk_hex(input string name, input logic [6:0] exp [8]);
    for (int d = 0; d < 8; d++) chk(name, 64'(hx[d]), 64'(exp[d]));
  endtask

  initial begin
    logic [6:0] e_live [8];
    logic [6:0] e_1234 [8];
    logic [6:0] e_all0 [8];
    logic [6:0] e_allf [8];
    e_live = '{7'h03, 7'h02, 7'h0E, 7'h0E, 7'h79, 7'h40, 7'h40, 7'h40};
    e_1234 = '{7'h00, 7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79};
    e_all0 = '{7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};
    e_allf = '{7'h0E, 7'h0E, 7'h0E, 7'h0E, 7'h0E, 7'h0E, 7'h0E, 7'h0E};

    // Reset state, then release timing
    step(3);
    chk("rst_ledr", 64'(ledr), 64'h0);
    chk("rst_ledg", 64'(ledg), 64'h0);
    chk_hex("rst_hex", e_all0);
    chk("rst_ce_n", 64'(sram_ce_n), 64'h1);
    rst_n = 1'b1;
    step(1);
    chk("rel_edge1", 64'(ledr[17]), 64'h0);
    step(1);
    chk("rel_edge2", 64'(ledr[17]), 64'h1);

    // Live display of the switches while KEY[0] is held
    sw_data = 17'h1FF6B;
    key     = 4'b1110;
    step(2);
    chk("live_ledr", 64'(ledr), 64'h3FF6B);
    chk("live_ledg", 64'(ledg[3:0]), 64'h1);
    chk_hex("live_hex", e_live);
    key = 4'hF;
    step(3);

    // Two shifts build 12345678
    sw_data = 17'h01234;
    step(3);
    press(4'b1101, 3);
    chk("shift1_model", 64'(m_disp), 64'h00001234);
    chk("shift1_hex0", 64'(hex0), 64'h19);
    sw_data = 17'h05678;
    step(3);
    press(4'b1101, 5);
    chk("shift2_model", 64'(m_disp), 64'h12345678);
    chk_hex("shift2_hex", e_1234);

    // Clear, fill with all ones, then add 1 wraps to zero
    press(4'b0111, 2);
    sw_data = 17'h0FFFF;
    step(3);
    press(4'b1101, 2);
    press(4'b1101, 2);
    chk_hex("ones_hex", e_allf);
    sw_data = 17'h00001;
    step(3);
    press(4'b1011, 2);
    chk("wrap_model", 64'(m_disp), 64'h0);
    chk_hex("wrap_hex", e_all0);

    // Clear beats add when pressed together
    sw_data = 17'h0ABCD;
    step(3);
    press(4'b1101, 2);
    chk("abcd_hex0", 64'(hex0), 64'h21);
    press(4'b0011, 3);
    chk_hex("prio_clr_hex", e_all0);

    // Held add fires once
    sw_data = 17'h00005;
    step(3);
    press(4'b1011, 100);
    chk("hold_hex0", 64'(hex0), 64'h12);
    chk("hold_hex1", 64'(hex1), 64'h40);

    // Add beats shift when pressed together: 5 + 3 = 8
    sw_data = 17'h00003;
    step(3);
    press(4'b1001, 3);
    chk("prio_add_hex0", 64'(hex0), 64'h00);
    chk("prio_add_hex1", 64'(hex1), 64'h40);

    // Async reset in the middle of a press
    sw_data = 17'h00007;
    step(3);
    key = 4'b1101;
    step(1);
    #1 rst_n = 1'b0;
    #1;
    chk("async_ledr", 64'(ledr), 64'h0);
    chk("async_ledg", 64'(ledg), 64'h0);
    chk("async_hex0", 64'(hex0), 64'h40);
    key = 4'hF;
    step(2);
    rst_n = 1'b1;
    step(1);
    chk("rel2_edge1", 64'(ledr[17]), 64'h0);
    step(1);
    chk("rel2_edge2", 64'(ledr[17]), 64'h1);
    step(4);
    chk("post_rst_hex0", 64'(hex0), 64'h40);
    chk("post_rst_model", 64'(m_disp), 64'h0);
    step(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
